// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register for a single demux channel.
module stream_demux_slot #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] d_data,
   input  logic              d_last,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              last,
   output logic              can_accept
);

   always_comb can_accept = !valid || ready;

   // A load wins over a drain so a back-to-back beat keeps valid asserted.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d_data;
         last  <= d_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware stream demultiplexer: routes each packet to the channel named
// by its first beat and discards packets whose select is out of range.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_W-1:0]         s_data,
   input  logic [SEL_W-1:0]          s_sel,
   input  logic                      s_last,
   output logic [NUM_OUT-1:0]        m_valid,
   input  logic [NUM_OUT-1:0]        m_ready,
   output logic [NUM_OUT*DATA_W-1:0] m_data,
   output logic [NUM_OUT-1:0]        m_last,
   output logic [DROP_CNT_W-1:0]     drop_cnt
);

   localparam logic [SEL_W:0] NUM_OUT_X = (SEL_W+1)'(NUM_OUT);

   state_t             state;
   logic [SEL_W-1:0]   route_q;
   logic [SEL_W-1:0]   target;
   logic               in_range;
   logic               drop_now;
   logic               target_ok;
   logic               accept;
   logic [NUM_OUT-1:0] slot_ok;
   logic [NUM_OUT-1:0] load;

   // The head beat is steered by s_sel directly; later beats follow route_q.
   always_comb begin
      in_range  = {1'b0, s_sel} < NUM_OUT_X;
      target    = (state == IDLE) ? s_sel : route_q;
      drop_now  = (state == DROP) || ((state == IDLE) && !in_range);
      target_ok = 1'b0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         if (target == SEL_W'(k)) target_ok = slot_ok[k];
      end
      s_ready = !rst && (drop_now || target_ok);
      accept  = s_valid && s_ready;
      load    = '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
         load[k] = accept && !drop_now && (target == SEL_W'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         route_q  <= '0;
         drop_cnt <= '0;
      end else if (accept) begin
         unique case (state)
            IDLE: begin
               route_q <= s_sel;
               if (!in_range && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
               if (!s_last) state <= in_range ? FWD : DROP;
            end
            FWD, DROP: begin
               if (s_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk        (clk),
         .rst        (rst),
         .load       (load[k]),
         .d_data     (s_data),
         .d_last     (s_last),
         .ready      (m_ready[k]),
         .valid      (m_valid[k]),
         .data       (m_data[k*DATA_W +: DATA_W]),
         .last       (m_last[k]),
         .can_accept (slot_ok[k])
      );
   end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed vectors on a 4-channel
// instance, drop/saturation and a random scoreboard soak on a 3-channel one.
module tb_stream_demux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [3:0]  s_data = '0;
   logic [1:0]  s_sel = '0;
   logic        s_last = 1'b0;
   logic [3:0]  m_valid;
   logic [3:0]  m_ready = '1;
   logic [15:0] m_data;
   logic [3:0]  m_last;
   logic [7:0]  drop_cnt;

   logic        b_s_valid = 1'b0;
   logic        b_s_ready;
   logic [3:0]  b_s_data = '0;
   logic [1:0]  b_s_sel = '0;
   logic        b_s_last = 1'b0;
   logic [2:0]  b_m_valid;
   logic [2:0]  b_m_ready = '1;
   logic [11:0] b_m_data;
   logic [2:0]  b_m_last;
   logic [7:0]  b_drop_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stream_demux #(.DATA_W(4), .NUM_OUT(4)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_sel(s_sel), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .drop_cnt(drop_cnt)
   );

   stream_demux #(.DATA_W(4), .NUM_OUT(3)) u_dut3 (
      .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
      .s_sel(b_s_sel), .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready),
      .m_data(b_m_data), .m_last(b_m_last), .drop_cnt(b_drop_cnt)
   );

   typedef struct {
      logic [1:0] sel;
      logic [3:0] data;
      logic [3:0] exp_valid;
      logic [3:0] exp_data;
   } vec_t;

   // Reference model for the soak: per-channel expected {last,data} FIFOs.
   logic [4:0] q0[$];
   logic [4:0] q1[$];
   logic [4:0] q2[$];
   int         model_drop;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_b_s_ready", b_s_ready, 0);
      chk("rst_b_m_valid", b_m_valid, 0);
      chk("rst_b_drop_cnt", b_drop_cnt, 0);
      tick();
      rst = 1'b0;
   endtask

   task automatic drain_check();
      logic [4:0] e;
      int         sz;
      for (int k = 0; k < 3; k++) begin
         if (b_m_valid[k] && b_m_ready[k]) begin
            sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
            if (sz == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL soak_extra ch%0d: got beat %0h, expected none", k,
                        {b_m_last[k], b_m_data[k*4 +: 4]});
            end else begin
               case (k)
                  0:       e = q0.pop_front();
                  1:       e = q1.pop_front();
                  default: e = q2.pop_front();
               endcase
               chk($sformatf("soak_beat_ch%0d", k), {b_m_last[k], b_m_data[k*4 +: 4]}, e);
            end
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[4];
      vecs[0] = '{sel: 2'd0, data: 4'h0, exp_valid: 4'b0001, exp_data: 4'h0};
      vecs[1] = '{sel: 2'd1, data: 4'hF, exp_valid: 4'b0010, exp_data: 4'hF};
      vecs[2] = '{sel: 2'd2, data: 4'h5, exp_valid: 4'b0100, exp_data: 4'h5};
      vecs[3] = '{sel: 2'd3, data: 4'hA, exp_valid: 4'b1000, exp_data: 4'hA};

      do_reset();

      // Single-beat packets to every channel.
      for (int i = 0; i < 4; i++) begin
         s_sel = vecs[i].sel; s_data = vecs[i].data; s_last = 1'b1; s_valid = 1'b1;
         @(negedge clk);
         chk("single_s_ready", s_ready, 1);
         tick();
         s_valid = 1'b0;
         @(negedge clk);
         chk("single_m_valid", m_valid, vecs[i].exp_valid);
         chk("single_m_data", m_data[vecs[i].sel*4 +: 4], vecs[i].exp_data);
         chk("single_m_last", m_last[vecs[i].sel], 1);
         tick();
      end

      // 3-beat packet to channel 2 with s_sel changing mid-packet.
      for (int b = 0; b < 3; b++) begin
         s_sel = (b == 0) ? 2'd2 : 2'd1; s_data = 4'(b + 1); s_last = (b == 2); s_valid = 1'b1;
         tick();
         @(negedge clk);
         chk("pkt_m_valid", m_valid, 4'b0100);
         chk("pkt_m_data", m_data[11:8], b + 1);
         chk("pkt_m_last", m_last[2], (b == 2));
      end
      tick();
      s_valid = 1'b0;
      tick();

      // Backpressure on channel 1.
      m_ready = 4'b1101;
      s_sel = 2'd1; s_data = 4'h3; s_last = 1'b0; s_valid = 1'b1;
      @(negedge clk);
      chk("bp_first_ready", s_ready, 1);
      tick();
      s_sel = 2'd0; s_data = 4'h9; s_last = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_s_ready_low", s_ready, 0);
         chk("bp_hold_valid", m_valid, 4'b0010);
         chk("bp_hold_data", m_data[7:4], 4'h3);
         chk("bp_hold_last", m_last[1], 0);
         tick();
      end
      m_ready = '1;
      @(negedge clk);
      chk("bp_s_ready_high", s_ready, 1);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("bp_swap_valid", m_valid, 4'b0010);
      chk("bp_swap_data", m_data[7:4], 4'h9);
      chk("bp_swap_last", m_last[1], 1);
      tick();
      @(negedge clk);
      chk("bp_drained_valid", m_valid, 0);
      chk("bp_data_held", m_data[7:4], 4'h9);
      tick();

      // Reset in the middle of a 4-beat packet.
      s_sel = 2'd2; s_data = 4'h6; s_last = 1'b0; s_valid = 1'b1;
      tick();
      s_data = 4'h7; s_sel = 2'd3;
      @(negedge clk);
      chk("mid_beat0", m_valid, 4'b0100);
      tick();
      rst = 1'b1; s_data = 4'h8;
      @(negedge clk);
      chk("mid_rst_s_ready", s_ready, 0);
      tick();
      rst = 1'b0; s_sel = 2'd1; s_data = 4'hC; s_last = 1'b1;
      @(negedge clk);
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_m_data", m_data, 0);
      chk("mid_rst_m_last", m_last, 0);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("mid_new_head_valid", m_valid, 4'b0010);
      chk("mid_new_head_data", m_data[7:4], 4'hC);
      tick();

      // 3-channel instance: 2-beat packet to sel=3 dropped, then sel=0 delivered.
      b_s_sel = 2'd3; b_s_data = 4'h1; b_s_last = 1'b0; b_s_valid = 1'b1;
      @(negedge clk);
      chk("drop_b0_ready", b_s_ready, 1);
      tick();
      b_s_sel = 2'd0; b_s_data = 4'h2; b_s_last = 1'b1;
      @(negedge clk);
      chk("drop_b1_ready", b_s_ready, 1);
      chk("drop_b0_not_out", b_m_valid, 0);
      chk("drop_cnt_one", b_drop_cnt, 1);
      tick();
      b_s_sel = 2'd0; b_s_data = 4'h7; b_s_last = 1'b1;
      @(negedge clk);
      chk("drop_b1_not_out", b_m_valid, 0);
      tick();
      b_s_valid = 1'b0;
      @(negedge clk);
      chk("after_drop_valid", b_m_valid, 3'b001);
      chk("after_drop_data", b_m_data[3:0], 4'h7);
      chk("after_drop_cnt", b_drop_cnt, 1);
      tick();

      // Random soak with mixed in-range and out-of-range packets.
      do_reset();
      model_drop = 0;
      begin
         int         pkt_rem = 0;
         logic [1:0] pkt_dest = '0;
         bit         first = 1'b0;
         bit         hs;
         for (int cyc = 0; cyc < 3000; cyc++) begin
            b_m_ready = 3'($urandom);
            if (!b_s_valid && ($urandom_range(0, 3) != 0)) begin
               if (pkt_rem == 0) begin
                  pkt_dest = 2'($urandom_range(0, 3));
                  pkt_rem  = $urandom_range(1, 4);
                  first    = 1'b1;
               end
               b_s_sel   = first ? pkt_dest : 2'($urandom);
               b_s_data  = 4'($urandom);
               b_s_last  = (pkt_rem == 1);
               b_s_valid = 1'b1;
            end
            @(negedge clk);
            drain_check();
            hs = b_s_valid && b_s_ready;
            if (hs) begin
               if (pkt_dest == 2'd0) q0.push_back({b_s_last, b_s_data});
               else if (pkt_dest == 2'd1) q1.push_back({b_s_last, b_s_data});
               else if (pkt_dest == 2'd2) q2.push_back({b_s_last, b_s_data});
               else if (first && model_drop < 255) model_drop++;
               pkt_rem--;
               first = 1'b0;
            end
            tick();
            if (hs) b_s_valid = 1'b0;
         end
         // Finish any open packet so the routing state returns to idle.
         while (pkt_rem > 0) begin
            b_m_ready = '1;
            b_s_sel = 2'($urandom); b_s_data = 4'($urandom); b_s_last = (pkt_rem == 1);
            b_s_valid = 1'b1;
            @(negedge clk);
            drain_check();
            hs = b_s_ready;
            if (hs) begin
               if (pkt_dest == 2'd0) q0.push_back({b_s_last, b_s_data});
               else if (pkt_dest == 2'd1) q1.push_back({b_s_last, b_s_data});
               else if (pkt_dest == 2'd2) q2.push_back({b_s_last, b_s_data});
               pkt_rem--;
            end
            tick();
            b_s_valid = 1'b0;
         end
         b_m_ready = '1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drain_check();
            tick();
         end
         chk("soak_q_empty", q0.size() + q1.size() + q2.size(), 0);
         chk("soak_drop_cnt", b_drop_cnt, model_drop);
      end

      // Drop counter saturation.
      do_reset();
      b_s_sel = 2'd3; b_s_data = 4'h5; b_s_last = 1'b1; b_s_valid = 1'b1;
      repeat (254) @(posedge clk);
      #1;
      b_s_valid = 1'b0;
      @(negedge clk);
      chk("sat_254", b_drop_cnt, 254);
      tick();
      b_s_valid = 1'b1;
      tick();
      b_s_valid = 1'b0;
      @(negedge clk);
      chk("sat_255", b_drop_cnt, 255);
      tick();
      b_s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      b_s_valid = 1'b0;
      @(negedge clk);
      chk("sat_hold", b_drop_cnt, 255);
      chk("sat_no_output", b_m_valid, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_W, default 4: payload width in bits, legal range 1..64.
REQ-002 Parameter NUM_OUT, default 4: number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_OUT), minimum 1: select width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_valid  in  1  input beat valid.
REQ-007 s_ready  out  1  input beat accepted when s_valid and s_ready are both high.
REQ-008 s_data  in  DATA_W  input payload.
REQ-009 s_sel  in  SEL_W  destination channel; sampled on the first beat of a packet only.
REQ-010 s_last  in  1  marks the final beat of a packet.
REQ-011 m_valid  out  NUM_OUT  per-channel valid.
REQ-012 m_ready  in  NUM_OUT  per-channel ready.
REQ-013 m_data  out  NUM_OUT*DATA_W  channel k uses bits [k*DATA_W +: DATA_W].
REQ-014 m_last  out  NUM_OUT  per-channel last.
REQ-015 drop_cnt  out  8  saturating count of dropped packets.

Function
REQ-016 Each channel shall have a one-entry output register; an input beat appears on its channel exactly 1 cycle after acceptance.
REQ-017 The FSM shall have three states: IDLE, FWD and DROP.
REQ-018 IDLE: on the first accepted beat, the block shall latch s_sel into route_q.
REQ-019 IDLE transition, in-range select: the state shall go to FWD if s_sel < NUM_OUT and s_last = 0.
REQ-020 IDLE transition, out-of-range select: the state shall go to DROP if s_sel >= NUM_OUT and s_last = 0.
REQ-021 IDLE transition, single-beat packet: the state shall stay in IDLE if s_last = 1.
REQ-022 FWD and DROP: the state shall return to IDLE on the accepted beat with s_last = 1; s_sel shall be ignored mid-packet.
REQ-023 Routing: the block shall route every beat of a packet to the channel latched at the first beat, never splitting a packet across channels.
REQ-024 Backpressure: s_ready shall equal (~m_valid[t] | m_ready[t]) for target t, the channel selected in IDLE or route_q otherwise, giving full throughput when ready is held high.
REQ-025 Drop path: in DROP, and for an out-of-range first beat, s_ready shall be 1 and the beat shall be discarded.
REQ-026 Drop count: drop_cnt shall increment once per dropped packet, on its first beat, and saturate at 255.
REQ-027 Non-selected channels: m_valid shall stay 0 and m_data/m_last shall hold their last values; a channel's data shall change only on a load.
REQ-028 Simultaneous events: a drain (m_valid & m_ready) and a load on the same channel in the same cycle shall leave m_valid = 1 with the new beat.
REQ-029 Held entries: m_valid, m_data and m_last shall stay stable while m_valid = 1 and m_ready = 0.

Reset
REQ-030 During rst, all outputs shall be driven to reset values: m_valid all 0, m_data 0, m_last 0, drop_cnt 0, s_ready 0.
REQ-031 Reset shall place the FSM in IDLE and clear route_q.
REQ-032 Reset mid-packet shall abandon the packet: buffered beats are lost, and the first beat after reset is treated as a new packet head.

Structure
REQ-033 Package stream_demux_pkg shall hold the state_t enum {IDLE, FWD, DROP} and the DROP_CNT_W = 8 constant.
REQ-034 Sub-module stream_demux_slot shall implement the one-entry per-channel register and be instantiated NUM_OUT times in a generate loop.

Verification
REQ-035 Default configuration, m_ready all 1: send 4 single-beat packets, data 0x0/0xF/0x5/0xA to sel 0..3 -> each value appears on its channel 1 cycle later, with the other m_valid bits 0.
REQ-036 Send a 3-beat packet to sel=2, changing s_sel to 1 on beats 2-3 -> all 3 beats appear on channel 2 only, and m_last is set on beat 3.
REQ-037 Hold m_ready[1]=0 and send 2 beats to sel=1 -> the first beat is held stable, s_ready=0 until m_ready[1]=1, then 1 beat per cycle.
REQ-038 NUM_OUT=3: send a 2-beat packet to sel=3, then a beat to sel=0 -> both dropped beats get s_ready=1, drop_cnt=1, and the sel=0 beat is delivered.
REQ-039 Assert rst for 1 cycle in the middle of a 4-beat packet -> all outputs at reset values, and the next beat is routed by its own s_sel.
REQ-040 Send 256+ out-of-range packets -> drop_cnt saturates at 255; the bench shall also run a random soak with a scoreboard checking per-channel order.
